// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared state encoding, sync byte and default parameters for the UART loader.
// Rev 1.0
`default_nettype none
package uart_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DAT_LO = 3'd3,
        S_DAT_HI = 3'd4,
        S_WRITE  = 3'd5,
        S_CHECK  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         DEF_ADDR_W    = 16;
    localparam int         DEF_BASE_ADDR = 0;
    localparam int         DEF_TIMEOUT   = 800000;
endpackage
`default_nettype wire

// File: rtl/uart_loader_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous level plus rising-edge pulse.
// Rev 1.0
`default_nettype none
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
// uart_loader: parses A5/count/data frames from a UART and writes 16-bit words to memory.
// Optional trailing XOR checksum enabled by UART_LOADER_CHECKSUM_EN.  Rev 1.0
`default_nettype none
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_t END_ST = S_CHECK;
`else
    localparam state_t END_ST = S_DONE;
`endif

    state_t            r_state;
    state_t            w_next;
    logic              w_strobe;
    logic              r_hold_vld;
    logic [7:0]        r_hold_byte;
    logic [15:0]       r_remain;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic              r_err;
    logic [31:0]       r_tmo;
    logic              w_consume;
    logic              w_overrun;
    logic              w_timeout;
    logic              w_counting;
    logic              w_sync;
    logic              w_accept;
    logic              w_csum_err;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx_ready),
        .o_rise  (w_strobe)
    );

    // WRITE and DONE leave a pending byte in the holding register for later.
    assign w_consume  = r_hold_vld && (r_state != S_WRITE) && (r_state != S_DONE);
    assign w_overrun  = w_strobe && r_hold_vld && !w_consume;
    assign w_counting = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_WRITE);
    assign w_timeout  = w_counting && !w_strobe && (r_tmo == 32'(TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        w_sync     = 1'b0;
        w_accept   = 1'b0;
        w_csum_err = 1'b0;
        case (r_state)
            S_IDLE:   if (w_consume && r_hold_byte == SYNC_BYTE) begin
                          w_next = S_CNT_LO;
                          w_sync = 1'b1;
                      end
            S_CNT_LO: if (w_consume) w_next = S_CNT_HI;
            S_CNT_HI: if (w_consume) w_next = ({r_hold_byte, r_remain[7:0]} == 16'd0) ? END_ST : S_DAT_LO;
            S_DAT_LO: if (w_consume) w_next = S_DAT_HI;
            S_DAT_HI: if (w_consume) w_next = S_WRITE;
            S_WRITE:  if (!mem_busy) begin
                          w_accept = 1'b1;
                          w_next   = (r_remain == 16'd1) ? END_ST : S_DAT_LO;
                      end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CHECK:  if (w_consume) begin
                          w_csum_err = (r_hold_byte != r_csum);
                          w_next     = w_csum_err ? S_IDLE : S_DONE;
                      end
`endif
            default:  w_next = S_IDLE;
        endcase
        if (w_overrun || w_timeout) begin
            w_next   = S_IDLE;
            w_accept = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold_vld  <= 1'b0;
            r_hold_byte <= 8'd0;
            r_remain    <= 16'd0;
            r_addr      <= ADDR_W'(BASE_ADDR);
            r_data      <= 16'd0;
            r_err       <= 1'b0;
            r_tmo       <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_strobe) begin
                r_hold_vld  <= !w_overrun;
                r_hold_byte <= rx_data;
            end else if (w_consume) begin
                r_hold_vld  <= 1'b0;
            end
            if (w_sync) begin
                r_addr   <= ADDR_W'(BASE_ADDR);
                r_remain <= 16'd0;
            end
            if (w_consume) begin
                case (r_state)
                    S_CNT_LO: r_remain[7:0]  <= r_hold_byte;
                    S_CNT_HI: r_remain[15:8] <= r_hold_byte;
                    S_DAT_LO: r_data[7:0]    <= r_hold_byte;
                    S_DAT_HI: r_data[15:8]   <= r_hold_byte;
                    default:  ;
                endcase
            end
            if (w_accept) begin
                r_addr   <= r_addr + 1'b1;
                r_remain <= r_remain - 16'd1;
            end
            if (w_sync)
                r_err <= 1'b0;
            else if (w_overrun || w_timeout || w_csum_err)
                r_err <= 1'b1;
            if (w_strobe || (w_next != r_state))
                r_tmo <= 32'd0;
            else if (w_counting)
                r_tmo <= r_tmo + 32'd1;
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_csum <= 8'd0;
        else if (w_sync)
            r_csum <= 8'd0;
        else if (w_consume && (r_state inside {S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI}))
            r_csum <= r_csum ^ r_hold_byte;
    end
`endif

    assign mem_addr = r_addr;
    assign mem_data = r_data;
    assign mem_we   = (r_state == S_WRITE) && !w_overrun;
    assign cpu_hold = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done     = (r_state == S_DONE);
    assign err      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames against a frame-level reference model of the loader.
// Rev 1.0
`default_nettype none
module tb_uart_loader;
    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        mem_busy = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [7:0]  tx_q[$];
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_d_q[$];
    logic [15:0] log_a[$];
    logic [15:0] log_d[$];

    uart_loader #(.ADDR_W(16), .BASE_ADDR(0), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_busy (mem_busy),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && !mem_busy) begin
                log_a.push_back(mem_addr);
                log_d.push_back(mem_data);
                if (exp_a_q.size() == 0) begin
                    check("unexpected_write", {mem_addr, mem_data}, 32'hFFFF_FFFF);
                end else begin
                    check("write", {mem_addr, mem_data}, {exp_a_q.pop_front(), exp_d_q.pop_front()});
                end
            end
            if (mem_we) check("we_implies_hold", cpu_hold, 1'b1);
            if (done) begin
                done_cnt++;
                check("hold_low_on_done", cpu_hold, 1'b0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        cycles(6);
        rx_ready = 1'b0;
        cycles(6);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
    endtask

    // Frame-level model: locate sync, decode count and words, then checksum if built in.
    task automatic model_frame(output int d, output logic e);
        int i;
        int n;
        logic [7:0]  cs;
        logic [15:0] a;
        d = 0;
        e = 1'b0;
        i = 0;
        while (i < tx_q.size() && tx_q[i] != 8'hA5) i++;
        if (i + 2 >= tx_q.size()) return;
        n  = {tx_q[i+2], tx_q[i+1]};
        cs = tx_q[i+1] ^ tx_q[i+2];
        i  = i + 3;
        a  = 16'd0;
        for (int w = 0; w < n; w++) begin
            if (i + 1 >= tx_q.size()) return;
            exp_a_q.push_back(a);
            exp_d_q.push_back({tx_q[i+1], tx_q[i]});
            cs = cs ^ tx_q[i] ^ tx_q[i+1];
            a  = a + 16'd1;
            i  = i + 2;
        end
`ifdef UART_LOADER_CHECKSUM_EN
        if (i >= tx_q.size()) return;
        if (tx_q[i] == cs) d = 1;
        else e = 1'b1;
`else
        d = 1;
`endif
    endtask

    task automatic add_csum();
`ifdef UART_LOADER_CHECKSUM_EN
        logic [7:0] cs = 8'd0;
        int i = 0;
        while (tx_q[i] != 8'hA5) i++;
        for (int k = i + 1; k < tx_q.size(); k++) cs = cs ^ tx_q[k];
        tx_q.push_back(cs);
`endif
    endtask

    task automatic run_frame(input string nm);
        int   d;
        int   d0;
        logic e;
        log_a.delete();
        log_d.delete();
        model_frame(d, e);
        d0 = done_cnt;
        send_q();
        cycles(20);
        check({nm, "_writes_left"}, exp_a_q.size(), 0);
        check({nm, "_done"}, done_cnt - d0, d);
        check({nm, "_err"}, err, e);
        check({nm, "_hold"}, cpu_hold, 1'b0);
    endtask

    initial begin
        int d0;
        logic stall_ok;
        cycles(2);
        check("rst_addr", mem_addr, 16'h0);
        check("rst_data", mem_data, 16'h0);
        check("rst_we", mem_we, 1'b0);
        check("rst_hold", cpu_hold, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        cycles(3);

        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        add_csum();
        run_frame("two_words");
        check("lit_w0", {log_a[0], log_d[0]}, 32'h0000_1234);
        check("lit_w1", {log_a[1], log_d[1]}, 32'h0001_5678);

        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB};
        add_csum();
        run_frame("lead_junk");
        check("lit_abcd", {log_a[0], log_d[0]}, 32'h0000_ABCD);

        send_byte(8'hA5);
        check("hold_after_sync", cpu_hold, 1'b1);
        tx_q = '{8'h00, 8'h00};
`ifdef UART_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h00);
`endif
        d0 = done_cnt;
        send_q();
        cycles(20);
        check("zero_done", done_cnt - d0, 1);
        check("zero_hold", cpu_hold, 1'b0);
        check("zero_err", err, 1'b0);

        // Stalled write with the next byte arriving meanwhile, longer than the timeout.
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        add_csum();
        begin
            int   d;
            logic e;
            model_frame(d, e);
            d0 = done_cnt;
            for (int i = 0; i < 4; i++) send_byte(tx_q[i]);
            mem_busy = 1'b1;
            send_byte(tx_q[4]);
            send_byte(tx_q[5]);
            stall_ok = 1'b1;
            repeat (TMO + 50) begin
                @(negedge clk);
                if (!mem_we || mem_data != 16'h2211) stall_ok = 1'b0;
            end
            check("stall_we_held", stall_ok, 1'b1);
            check("stall_no_err", err, 1'b0);
            cycles(1);
            mem_busy = 1'b0;
            for (int i = 6; i < tx_q.size(); i++) send_byte(tx_q[i]);
            cycles(20);
            check("stall_writes_left", exp_a_q.size(), 0);
            check("stall_done", done_cnt - d0, d);
            check("stall_err", err, e);
        end

        // Silence mid-frame.
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        cycles(TMO + 50);
        check("tmo_err", err, 1'b1);
        check("tmo_hold", cpu_hold, 1'b0);
        check("tmo_done", done_cnt - d0, 0);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        cycles(10);
        check("tmo_idle", cpu_hold, 1'b0);

        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h0F, 8'hF0};
        add_csum();
        run_frame("after_tmo");

        // Two bytes during a stalled write overrun the holding register.
        d0 = done_cnt;
        mem_busy = 1'b1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        cycles(2);
        check("ovr_err", err, 1'b1);
        check("ovr_we", mem_we, 1'b0);
        check("ovr_hold", cpu_hold, 1'b0);
        mem_busy = 1'b0;
        cycles(10);
        check("ovr_done", done_cnt - d0, 0);

        // Reset mid-load discards the frame.
        d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        do_reset();
        check("mid_rst_addr", mem_addr, 16'h0);
        check("mid_rst_hold", cpu_hold, 1'b0);
        check("mid_rst_data", mem_data, 16'h0);
        send_byte(8'h22);
        send_byte(8'h33);
        cycles(20);
        check("mid_rst_done", done_cnt - d0, 0);

        tx_q = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF};
        add_csum();
        run_frame("three_words");

`ifdef UART_LOADER_CHECKSUM_EN
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'hAA, 8'h00};
        run_frame("bad_csum");
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'hAA, 8'hFE};
        run_frame("good_csum");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
